// File: rtl/cr_axi4s_pkt_arb.sv
// cr_axi4s_pkt_arb: packet-aware round-robin arbiter. It pops beats from
// N_PORTS show-ahead ingress FIFOs onto one registered AXI4-stream output.
// A grant is held from a packet's first beat through its tlast beat, so
// packets from different ports are never interleaved.

package cr_axi4s_pkt_arb_pkg;

  typedef struct packed {
    logic        tvalid;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tlast;
    logic [3:0]  tid;
    logic [3:0]  tuser;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

endpackage

module cr_axi4s_pkt_arb
  import cr_axi4s_pkt_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_PORTS-1:0]  src_empty,
  input  axi4s_dp_bus_t       src_rdata [N_PORTS],
  output logic [N_PORTS-1:0]  src_rd,
  input  logic [N_PORTS-1:0]  port_en,
  input  axi4s_dp_rdy_t       axi4s_ob_in,
  output axi4s_dp_bus_t       axi4s_ob_out,
  output logic [PORT_W-1:0]   ob_src,
  output logic                arb_busy
);

  // Port count at the width used for modulo arithmetic on port indices.
  localparam logic [PORT_W:0] NP_L = (PORT_W+1)'(N_PORTS);

  // (base + offs) modulo N_PORTS; base < N_PORTS and offs < N_PORTS, so a
  // single conditional subtraction is enough.
  function automatic logic [PORT_W-1:0] wrap_add(
    input logic [PORT_W-1:0] base,
    input logic [PORT_W:0]   offs
  );
    logic [PORT_W:0] sum;
    sum = {1'b0, base} + offs;
    if (sum >= NP_L) begin
      sum = sum - NP_L;
    end else begin
      sum = sum;
    end
    return sum[PORT_W-1:0];
  endfunction

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [PORT_W-1:0] rr_ptr_r;
  logic [PORT_W-1:0] rr_ptr_nxt_s;
  logic [PORT_W-1:0] grant_r;
  logic [PORT_W-1:0] grant_nxt_s;

  logic              can_load_s;
  logic              found_s;
  logic [PORT_W-1:0] cand_s;
  logic [PORT_W-1:0] idx_s;
  logic              pop_s;
  logic [PORT_W-1:0] pop_port_s;
  logic              pop_last_s;
  logic              ob_tvalid_nxt_s;
  axi4s_dp_bus_t     ob_load_s;

  axi4s_dp_bus_t     ob_r;
  logic [PORT_W-1:0] ob_src_r;
  logic              busy_r;

  // The output register can take a new beat when empty or being drained now.
  assign can_load_s = ~ob_r.tvalid | axi4s_ob_in.tready;

  // Round-robin search: scan from rr_ptr upward; lowest offset wins, so the
  // loop runs from the far end and lets nearer hits overwrite.
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    idx_s   = '0;
    for (int k = N_PORTS - 1; k >= 0; k--) begin
      idx_s = wrap_add(rr_ptr_r, (PORT_W+1)'(k));
      if (~src_empty[idx_s] & port_en[idx_s]) begin
        found_s = 1'b1;
        cand_s  = idx_s;
      end else begin
        found_s = found_s;
        cand_s  = cand_s;
      end
    end
  end

  // FSM state register together with the pointer and the held grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      rr_ptr_r <= '0;
      grant_r  <= '0;
    end else begin
      state_r  <= state_nxt_s;
      rr_ptr_r <= rr_ptr_nxt_s;
      grant_r  <= grant_nxt_s;
    end
  end

  // FSM next state: lock onto a port on a non-tlast pop, release on tlast.
  always_comb begin
    state_nxt_s  = state_r;
    rr_ptr_nxt_s = rr_ptr_r;
    grant_nxt_s  = grant_r;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          grant_nxt_s = pop_port_s;
          if (pop_last_s) begin
            state_nxt_s  = ST_IDLE;
            rr_ptr_nxt_s = wrap_add(pop_port_s, (PORT_W+1)'(1));
          end else begin
            state_nxt_s  = ST_LOCKED;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (pop_s & pop_last_s) begin
          state_nxt_s  = ST_IDLE;
          rr_ptr_nxt_s = wrap_add(grant_r, (PORT_W+1)'(1));
        end else begin
          state_nxt_s  = ST_LOCKED;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: which port pops this cycle. Depends only on state, flags,
  // enables, pointer and can_load -- never on the FIFO data.
  always_comb begin
    pop_s      = 1'b0;
    pop_port_s = '0;
    src_rd     = '0;
    case (state_r)
      ST_IDLE: begin
        pop_s      = found_s & can_load_s;
        pop_port_s = cand_s;
      end
      ST_LOCKED: begin
        // port_en is deliberately ignored: a started packet always finishes.
        pop_s      = ~src_empty[grant_r] & can_load_s;
        pop_port_s = grant_r;
      end
      default: begin
        pop_s      = 1'b0;
        pop_port_s = '0;
      end
    endcase
    pop_s = pop_s & ~rst;
    if (pop_s) begin
      src_rd[pop_port_s] = 1'b1;
    end else begin
      src_rd = '0;
    end
  end

  assign pop_last_s = src_rdata[pop_port_s].tlast;

  // Beat to load: head of the popped FIFO with tvalid forced, since the
  // source tvalid field carries no meaning (non-empty defines validity).
  always_comb begin
    ob_load_s        = src_rdata[pop_port_s];
    ob_load_s.tvalid = 1'b1;
    ob_tvalid_nxt_s  = pop_s | (ob_r.tvalid & ~axi4s_ob_in.tready);
  end

  // Output beat register, source index and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ob_r     <= '0;
      ob_src_r <= '0;
      busy_r   <= 1'b0;
    end else begin
      if (pop_s) begin
        ob_r     <= ob_load_s;
        ob_src_r <= pop_port_s;
      end else if (axi4s_ob_in.tready) begin
        ob_r.tvalid <= 1'b0;
      end else begin
        ob_r     <= ob_r;
        ob_src_r <= ob_src_r;
      end
      busy_r <= (state_nxt_s == ST_LOCKED) | ob_tvalid_nxt_s;
    end
  end

  assign axi4s_ob_out = ob_r;
  assign ob_src       = ob_src_r;
  assign arb_busy     = busy_r;

endmodule

// File: doc/cr_axi4s_pkt_arb.md
# cr_axi4s_pkt_arb

Packet-aware round-robin arbiter that shares one downstream AXI4-stream data-path port among `N_PORTS` ingress slave FIFOs. It pops beats from the granted FIFO's show-ahead read side (`*_empty` / `*_rd` / `*_out` style) and drives a registered `axi4s_dp_bus_t` master output with `tready` backpressure. A grant is held from a packet's first beat through its `tlast` beat, so packets are never interleaved. It sits between the per-source `cr_axi4s_slv` instances and a single shared consumer.

## Interface
- `N_PORTS`, 4: number of ingress FIFOs; legal range 2..8.
- `PORT_W`, `$clog2(N_PORTS)`: width of the port-index fields.
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `src_empty` input `N_PORTS`: per-FIFO empty flag.
- `src_rdata` input `axi4s_dp_bus_t [N_PORTS]`: per-FIFO show-ahead head beat; valid whenever the matching `src_empty` bit is 0.
- `src_rd` output `N_PORTS`: per-FIFO pop strobe; one-hot or zero.
- `port_en` input `N_PORTS`: per-port enable; gates new grants only.
- `axi4s_ob_in` input `axi4s_dp_rdy_t`: downstream `tready`.
- `axi4s_ob_out` output `axi4s_dp_bus_t`: registered output beat.
- `ob_src` output `PORT_W`: index of the port that sourced the current `axi4s_ob_out` beat.
- `arb_busy` output 1: high while in LOCKED or while `axi4s_ob_out.tvalid` is 1.

## Operation
- **Output stage.** A single register holds the output beat.
  - `can_load = ~axi4s_ob_out.tvalid | axi4s_ob_in.tready`.
  - A pop happens only when `can_load` is 1.
- **State machine.** Two states: IDLE and LOCKED(g).
- **IDLE.**
  - Candidates: ports with `~src_empty[i] & port_en[i]`.
  - Search starts at `rr_ptr` and increases modulo `N_PORTS`; the first candidate found is g.
  - If a candidate exists and `can_load` is 1: assert `src_rd[g]` and load `src_rdata[g]` into the output register with `tvalid` forced to 1.
  - Popped beat has `tlast` = 1: stay in IDLE and set `rr_ptr <= (g+1) % N_PORTS`.
  - Popped beat has `tlast` = 0: go to LOCKED(g); `rr_ptr` is unchanged.
  - No candidate, or `can_load` is 0: nothing is popped and nothing is granted; the search repeats next cycle.
- **LOCKED(g).**
  - Pop from g only, and only when `~src_empty[g] & can_load`.
  - `port_en[g]` is ignored here; disabling a port mid-packet does not abort the packet.
  - An empty port g stalls the stream, with no timeout. Other ports stay blocked.
  - Popping a `tlast` = 1 beat: go to IDLE and set `rr_ptr <= (g+1) % N_PORTS`.
- **Output register update.**
  - The `tvalid` field of the source beat is never consulted; `~src_empty` alone defines a valid beat.
  - All other fields (`tdata`, `tlast`, `tid`, `tuser`, `tstrb`) pass through unmodified.
  - `ob_src` is loaded with g together with the beat.
  - Loaded beat accepted with no new pop: `tvalid` clears to 0; the other fields hold their values.
- **Reset.** `rst` is sampled high at a rising edge.
  - State goes to IDLE and `rr_ptr` to 0.
  - `axi4s_ob_out` clears to all zeros (`tvalid` = 0); `ob_src` = 0; `arb_busy` = 0.
  - `src_rd` is 0 during the reset cycle.
  - Reset mid-packet drops the partial packet; no recovery is attempted.
- **`src_rd` decode.** `src_rd` is combinational from state, `src_empty`, `port_en`, `rr_ptr` and `can_load`. It never depends combinationally on `src_rdata`.

## Timing
- **Latency.** Pop at cycle t puts the beat on `axi4s_ob_out` at t+1.
- **Throughput.** One beat per cycle while `tready` = 1 and the granted FIFO stays non-empty.
- **Back-to-back packets.** Zero bubbles, within one port or across ports: the `tlast` pop at t returns to IDLE, and IDLE arbitrates and pops at t+1.
- **Backpressure.**
  - With `tvalid` = 1 and `tready` = 0: the output is held stable and no pop occurs.
  - With `tvalid` = 1 and `tready` = 1 in the same cycle: accept and load the next beat that same cycle.
- **Bounded wait.** A waiting enabled port is granted after at most `N_PORTS-1` other packets.

## Test plan
- **Single port.** `N_PORTS`=4, all enabled, one 3-beat packet in port 2, `tready`=1 → `src_rd[2]` high for 3 consecutive cycles; beats on `axi4s_ob_out` at +1 with `ob_src`=2; `tlast` on beat 3; `rr_ptr` ends at 3.
- **Round-robin order.** Ports 0, 1, 3 each hold two 2-beat packets, `rr_ptr`=0 → port order 0,1,3,0,1,3; 12 beats in 12 consecutive cycles with no bubble; no interleaving within a packet.
- **Backpressure.** Port 0 holds a 4-beat packet; `tready` is 0 on the cycles beat 2 is valid, for 3 cycles → beat 2 is held stable; `src_rd` stays 0 for those cycles; all 4 beats delivered in order.
- **Mid-packet stall and disable.** Port 1 sends beat 1 of 3, then goes empty for 5 cycles with `port_en[1]`=0, while port 2 holds data → no pop from port 2 until port 1's `tlast` pops; then port 2 is granted only if enabled.
- **Reset mid-packet.** `rst` is asserted for 1 cycle during beat 2 of a 4-beat packet → next cycle `tvalid`=0, `ob_src`=0, `arb_busy`=0, state IDLE, `rr_ptr`=0; the next grant follows the search from port 0.
- **Disabled port with data.** `port_en`=4'b1011 and port 2 non-empty → port 2 is never popped; re-enabling it grants port 2 within 3 packets.
